// File: rtl/mdu_hilo_sequencer.sv
// mdu_hilo_sequencer: iterative multiply/divide unit that owns the MIPS HI/LO registers.
//   MULT/MULTU use a shift-add datapath and DIV/DIVU a restoring divider; each produces one
//   bit per cycle over WIDTH cycles, followed by a FIN cycle that applies signs and commits.
//   MTHI/MTLO write HI/LO directly. MFHI/MFLO read combinationally through rd_data.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   run                global enable; 0 freezes the FSM and datapath and blocks accepts
//   op_valid, op_funct EX holds an MDU instruction (funct 0x18/19/1A/1B/11/13)
//   op_a, op_b         rs / rt operands
//   rd_req, rd_sel     EX holds MFHI/MFLO; rd_sel 1 = HI, 0 = LO
//   rd_data            committed HI or LO selected by rd_sel
//   hi, lo             committed HI/LO registers
//   busy, stall        operation in flight; hold EX while busy and EX needs the MDU
// Configuration:
//   MDU_EARLY_OUT_EN   when defined, MUL leaves for FIN once the remaining multiplier is zero
module mdu_hilo_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             op_valid,
  input  logic [5:0]       op_funct,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             rd_req,
  input  logic             rd_sel,
  output logic [WIDTH-1:0] rd_data,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             stall
);

  localparam int unsigned CW = $clog2(WIDTH);

  localparam logic [5:0] FnMult  = 6'h18;
  localparam logic [5:0] FnMultu = 6'h19;
  localparam logic [5:0] FnDiv   = 6'h1A;
  localparam logic [5:0] FnDivu  = 6'h1B;
  localparam logic [5:0] FnMthi  = 6'h11;
  localparam logic [5:0] FnMtlo  = 6'h13;

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StFin} state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        count_q, count_d;
  // MUL: 2W-bit product accumulator. DIV: {remainder, dividend/quotient shift register}.
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]     opb_q, opb_d;        // multiplier (shifted right) or divisor
  logic                 neg_quo_q, neg_quo_d;
  logic                 neg_rem_q, neg_rem_d;
  logic                 is_div_q, is_div_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;

  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? -x : x;
  endfunction

  logic             signed_op;
  logic [WIDTH-1:0] a_in, b_in;
  logic             last_iter;
  logic [WIDTH-1:0] mplier_next;
  logic [2*WIDTH-1:0] partial;
  logic [WIDTH:0]   div_shift, div_diff;
  logic [2*WIDTH-1:0] prod_signed;
  logic [WIDTH-1:0] quo_signed, rem_signed;

  assign signed_op   = (op_funct == FnMult) || (op_funct == FnDiv);
  assign a_in        = signed_op ? abs_val(op_a) : op_a;
  assign b_in        = signed_op ? abs_val(op_b) : op_b;
  assign last_iter   = (count_q == CW'(WIDTH - 1));
  assign mplier_next = opb_q >> 1;
  assign partial     = opb_q[0] ? ({{WIDTH{1'b0}}, mcand_q} << count_q) : '0;
  // Remainder shifted left with the next dividend bit; a clear borrow bit means it fits.
  assign div_shift   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_diff    = div_shift - {1'b0, opb_q};
  assign prod_signed = neg_quo_q ? -acc_q : acc_q;
  assign quo_signed  = neg_quo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_signed  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    opb_d     = opb_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    is_div_d  = is_div_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    if (run) begin
      case (state_q)
        StIdle: begin
          if (op_valid) begin
            case (op_funct)
              FnMult, FnMultu: begin
                mcand_d   = a_in;
                opb_d     = b_in;
                acc_d     = '0;
                count_d   = '0;
                neg_quo_d = signed_op & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                neg_rem_d = signed_op & op_a[WIDTH-1];
                is_div_d  = 1'b0;
`ifdef MDU_EARLY_OUT_EN
                state_d   = (b_in == '0) ? StFin : StMul;
`else
                state_d   = StMul;
`endif
              end
              FnDiv, FnDivu: begin
                opb_d    = b_in;
                count_d  = '0;
                is_div_d = 1'b1;
                if (op_b == '0) begin
                  // Divide by zero: FIN passes {rem, quo} through unsigned as {op_a, ones}.
                  acc_d     = {op_a, {WIDTH{1'b1}}};
                  neg_quo_d = 1'b0;
                  neg_rem_d = 1'b0;
                  state_d   = StFin;
                end else begin
                  acc_d     = {{WIDTH{1'b0}}, a_in};
                  neg_quo_d = signed_op & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                  neg_rem_d = signed_op & op_a[WIDTH-1];
                  state_d   = StDiv;
                end
              end
              FnMthi:  hi_d = op_a;
              FnMtlo:  lo_d = op_a;
              default: ;
            endcase
          end
        end
        StMul: begin
          acc_d   = acc_q + partial;
          opb_d   = mplier_next;
          count_d = count_q + CW'(1);
`ifdef MDU_EARLY_OUT_EN
          if (last_iter || (mplier_next == '0)) state_d = StFin;
`else
          if (last_iter) state_d = StFin;
`endif
        end
        StDiv: begin
          if (!div_diff[WIDTH]) begin
            acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_d = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
          end
          count_d = count_q + CW'(1);
          if (last_iter) state_d = StFin;
        end
        StFin: begin
          if (is_div_q) begin
            hi_d = rem_signed;
            lo_d = quo_signed;
          end else begin
            hi_d = prod_signed[2*WIDTH-1:WIDTH];
            lo_d = prod_signed[WIDTH-1:0];
          end
          count_d = '0;
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      count_q   <= '0;
      acc_q     <= '0;
      mcand_q   <= '0;
      opb_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      is_div_q  <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      opb_q     <= opb_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      is_div_q  <= is_div_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign hi      = hi_q;
  assign lo      = lo_q;
  assign busy    = (state_q != StIdle);
  assign stall   = busy & (op_valid | rd_req);
  assign rd_data = rd_sel ? hi_q : lo_q;

endmodule

// File: tb/tb_mdu_hilo_sequencer.sv
module tb_mdu_hilo_sequencer;

  logic        clk = 1'b0;
  logic        rst, run, op_valid, rd_req, rd_sel;
  logic [5:0]  op_funct;
  logic [31:0] op_a, op_b, rd_data, hi, lo;
  logic        busy, stall;

  int checks = 0;
  int failures = 0;

  mdu_hilo_sequencer #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .op_valid (op_valid),
    .op_funct (op_funct),
    .op_a     (op_a),
    .op_b     (op_b),
    .rd_req   (rd_req),
    .rd_sel   (rd_sel),
    .rd_data  (rd_data),
    .hi       (hi),
    .lo       (lo),
    .busy     (busy),
    .stall    (stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  funct;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          exp_busy;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%h required=0x%h", name, act, exp);
    end
  endtask

  // Busy cycles of a multiply: WIDTH+1 normally; with early-out, one per multiplier bit up to
  // the highest set bit of |b|, plus FIN (1 when |b| is zero).
  function automatic int mul_busy(input logic [31:0] b, input bit is_signed);
`ifdef MDU_EARLY_OUT_EN
    logic [31:0] babs;
    babs = (is_signed && b[31]) ? -b : b;
    for (int i = 31; i >= 0; i--) begin
      if (babs[i]) return i + 2;
    end
    return 1;
`else
    return 33;
`endif
  endfunction

  // Present an op for one cycle; returns at the falling edge of busy cycle 1.
  task automatic accept_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    op_valid = 1'b1;
    op_funct = f;
    op_a     = a;
    op_b     = b;
    @(negedge clk);
    op_valid = 1'b0;
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (busy && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  initial begin
    int cyc;
    int exp_busy;

    vecs[0]  = '{6'h18, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE, 33};
    vecs[1]  = '{6'h19, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, 33};
    vecs[2]  = '{6'h1A, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 33};
    vecs[3]  = '{6'h1B, 32'd100,      32'h00000000, 32'd100,      32'hFFFFFFFF, 1};
    vecs[4]  = '{6'h1A, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33};
    vecs[5]  = '{6'h11, 32'h12345678, 32'h0,        32'h12345678, 32'h80000000, 0};
    vecs[6]  = '{6'h13, 32'hCAFEF00D, 32'h0,        32'h12345678, 32'hCAFEF00D, 0};
    vecs[7]  = '{6'h1A, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 33};
    vecs[8]  = '{6'h18, 32'hFFFFFFFD, 32'hFFFFFFFC, 32'h00000000, 32'h0000000C, 33};
    vecs[9]  = '{6'h19, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 33};
    vecs[10] = '{6'h1B, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 33};
    vecs[11] = '{6'h20, 32'h1,        32'h1,        32'h0000000F, 32'h0FFFFFFF, 0};
    vecs[12] = '{6'h1A, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 1};
    vecs[13] = '{6'h19, 32'd3,        32'd5,        32'h00000000, 32'd15,       33};

    rst = 1'b1; run = 1'b1; op_valid = 1'b0; op_funct = '0; op_a = '0; op_b = '0;
    rd_req = 1'b0; rd_sel = 1'b0;
    repeat (2) @(negedge clk);
    rd_req = 1'b1;
    check("reset_hi", hi, 32'h0);
    check("reset_lo", lo, 32'h0);
    check("reset_busy", {31'b0, busy}, 32'h0);
    check("reset_stall", {31'b0, stall}, 32'h0);
    check("reset_rd_data", rd_data, 32'h0);
    rd_req = 1'b0;
    rst = 1'b0;

    // run=0 blocks accepts
    run = 1'b0;
    accept_op(6'h19, 32'd2, 32'd2);
    check("run0_no_accept", {31'b0, busy}, 32'h0);
    run = 1'b1;

    for (int i = 0; i < 14; i++) begin
      accept_op(vecs[i].funct, vecs[i].a, vecs[i].b);
      wait_idle(cyc);
      exp_busy = vecs[i].exp_busy;
      if (vecs[i].funct == 6'h18 || vecs[i].funct == 6'h19)
        exp_busy = mul_busy(vecs[i].b, vecs[i].funct == 6'h18);
      check($sformatf("vec%0d_busy_cycles", i), cyc, exp_busy);
      check($sformatf("vec%0d_hi", i), hi, vecs[i].exp_hi);
      check($sformatf("vec%0d_lo", i), lo, vecs[i].exp_lo);
      rd_sel = 1'b1;
      #1;
      check($sformatf("vec%0d_rd_hi", i), rd_data, vecs[i].exp_hi);
      rd_sel = 1'b0;
    end

    // MFLO right behind MULTU 6*7 stalls until busy drops
    accept_op(6'h19, 32'd6, 32'd7);
    rd_req = 1'b1;
    rd_sel = 1'b0;
    #1;
    cyc = 0;
    while (stall && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
    check("mflo_stall_cycles", cyc, mul_busy(32'd7, 1'b0));
    check("mflo_stall_released", {31'b0, stall}, 32'h0);
    check("mflo_rd_data", rd_data, 32'd42);
    rd_req = 1'b0;

    // Reset mid-divide aborts
    accept_op(6'h1B, 32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    check("abort_busy_c10", {31'b0, busy}, 32'h1);
    rst = 1'b1;
    rd_req = 1'b1;
    @(negedge clk);
    check("abort_busy", {31'b0, busy}, 32'h0);
    check("abort_hi", hi, 32'h0);
    check("abort_lo", lo, 32'h0);
    check("abort_stall", {31'b0, stall}, 32'h0);
    rst = 1'b0;
    rd_req = 1'b0;

    // run=0 for 5 cycles mid-divide delays completion by exactly 5
    accept_op(6'h1B, 32'd1000, 32'd3);
    cyc = 0;
    while (busy && cyc < 200) begin
      cyc++;
      if (cyc == 5) begin
        run = 1'b0;
        rd_req = 1'b1;
      end
      if (cyc == 7) check("freeze_stall", {31'b0, stall}, 32'h1);
      if (cyc == 10) begin
        run = 1'b1;
        rd_req = 1'b0;
      end
      @(negedge clk);
    end
    check("freeze_busy_cycles", cyc, 38);
    check("freeze_hi", hi, 32'd1);
    check("freeze_lo", lo, 32'd333);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
